// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store controller for a little-endian 4-byte-wide data memory
// Ports: CLK/Reset (sync, active-high); req/wr/size/sign_ext/addr/wdata request latched in IDLE;
// busy/done/err/rdata status and load result; mem_RW/mem_Addr/mem_DataIn/mem_DataOut memory side.
module mem_access_unit #(
  parameter int MEM_BYTES = 256,
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              mem_RW,
  output logic [ADDR_W-1:0] mem_Addr,
  output logic [31:0]       mem_DataIn,
  input  logic [31:0]       mem_DataOut
);
  typedef enum logic [2:0] {IDLE, CHK, RD, WR, FIN} state_t;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_BYTES);
  state_t state;
  logic wr_q, sx_q, err_q;
  logic [1:0] size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0] wdata_q;
  logic [ADDR_W:0] nbytes, end_addr;
  logic bad;
  logic [31:0] ld, mg;
  // end address is one bit wider than addr so a range check near the top cannot wrap
  assign nbytes = {{(ADDR_W-2){1'b0}}, size_q == 2'b00 ? 3'd1 : size_q == 2'b01 ? 3'd2 : 3'd4};
  assign end_addr = {1'b0, addr_q} + nbytes;
  assign bad = (size_q == 2'b11) | (size_q == 2'b01 & addr_q[0]) |
               (size_q == 2'b10 & |addr_q[1:0]) | (end_addr > LIMIT);
  assign ld = size_q == 2'b00 ? {{24{sx_q & mem_DataOut[7]}}, mem_DataOut[7:0]} :
              size_q == 2'b01 ? {{16{sx_q & mem_DataOut[15]}}, mem_DataOut[15:0]} : mem_DataOut;
  assign mg = size_q == 2'b00 ? {mem_DataOut[31:8], wdata_q[7:0]} : {mem_DataOut[31:16], wdata_q[15:0]};
  // combinational so a Reset during WR suppresses the negedge write of that cycle
  assign mem_RW = (state == WR) & ~Reset;
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      err_q <= 1'b0;
      rdata <= '0;
      mem_Addr <= '0;
      mem_DataIn <= '0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: if (req) begin
          wr_q <= wr;
          size_q <= size;
          sx_q <= sign_ext;
          addr_q <= addr;
          wdata_q <= wdata;
          busy <= 1'b1;
          state <= CHK;
        end
        CHK: begin
          err_q <= bad;
          if (bad) state <= FIN;
          else begin
            mem_Addr <= addr_q;
            mem_DataIn <= wdata_q;
            state <= (wr_q && size_q == 2'b10) ? WR : RD;
          end
        end
        RD: begin
          if (wr_q) begin
            mem_DataIn <= mg;
            state <= WR;
          end else begin
            rdata <= ld;
            mem_Addr <= '0;
            mem_DataIn <= '0;
            state <= FIN;
          end
        end
        WR: begin
          mem_Addr <= '0;
          mem_DataIn <= '0;
          state <= FIN;
        end
        FIN: begin
          done <= 1'b1;
          err <= err_q;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit with a byte-array memory model
module tb_mem_access_unit;
  logic CLK = 0, Reset = 1, req = 0, wr = 0, sign_ext = 0;
  logic [1:0] size = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic busy, done, err, mem_RW;
  logic [31:0] rdata, mem_Addr, mem_DataIn, mem_DataOut;
  logic [7:0] mem [256];
  typedef struct {int id; logic e; logic [31:0] r; int lat; int acc; bit crw;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0, cyc = 0, opn = 0;
  bit rw_seen = 0, last_b2b = 0;

  mem_access_unit #(.MEM_BYTES(256), .ADDR_W(32)) dut (
    .CLK(CLK), .Reset(Reset), .req(req), .wr(wr), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_RW(mem_RW), .mem_Addr(mem_Addr), .mem_DataIn(mem_DataIn), .mem_DataOut(mem_DataOut)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  assign mem_DataOut = {mem[8'(mem_Addr + 3)], mem[8'(mem_Addr + 2)], mem[8'(mem_Addr + 1)], mem[8'(mem_Addr)]};
  always @(negedge CLK) if (mem_RW) for (int i = 0; i < 4; i++) mem[8'(mem_Addr + 32'(i))] = mem_DataIn[8*i +: 8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    exp_t x;
    if (mem_RW) rw_seen = 1;
    if (done) begin
      if (q.size() == 0) chk("done_unexpected", 32'(done), 32'd0);
      else begin
        x = q.pop_front();
        chk($sformatf("op%0d err", x.id), 32'(err), 32'(x.e));
        chk($sformatf("op%0d rdata", x.id), rdata, x.r);
        chk($sformatf("op%0d latency", x.id), 32'(cyc - x.acc), 32'(x.lat));
        if (x.crw) chk($sformatf("op%0d no_mem_rw", x.id), 32'(rw_seen), 32'd0);
      end
      rw_seen = 0;
    end
  end

  task automatic issue(input logic w, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                       input logic [31:0] d, input logic e, input logic [31:0] r, input int lat, input bit push);
    int n = 0;
    while (busy && n < 50) begin @(negedge CLK); n++; end
    if (busy) chk("issue_timeout", 32'(busy), 32'd0);
    last_b2b = done;
    req = 1; wr = w; size = sz; sign_ext = sx; addr = a; wdata = d;
    @(negedge CLK);
    req = 0;
    opn++;
    chk($sformatf("op%0d accept", opn), 32'(busy), 32'd1);
    if (push) q.push_back('{opn, e, r, lat, cyc, e});
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 50) begin @(negedge CLK); n++; end
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, " busy"}, 32'(busy), 0);
    chk({nm, " done"}, 32'(done), 0);
    chk({nm, " err"}, 32'(err), 0);
    chk({nm, " rdata"}, rdata, 0);
    chk({nm, " mem_Addr"}, mem_Addr, 0);
    chk({nm, " mem_DataIn"}, mem_DataIn, 0);
    chk({nm, " mem_RW"}, 32'(mem_RW), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h22] = 8'h77; mem[8'h23] = 8'h66; mem[8'hFF] = 8'h80;
    repeat (2) @(negedge CLK);
    chk_idle("reset");
    Reset = 0;
    @(negedge CLK);
    issue(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0, 3, 1);
    issue(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 3, 1);
    drain();
    chk("mem10", 32'(mem[8'h10]), 32'hEF);
    chk("mem11", 32'(mem[8'h11]), 32'hBE);
    chk("mem12", 32'(mem[8'h12]), 32'hAD);
    chk("mem13", 32'(mem[8'h13]), 32'hDE);
    issue(1, 2'b00, 0, 32'h10, 32'hAAAAAA55, 0, 32'hDEADBEEF, 4, 1);
    issue(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'hDEADBE55, 3, 1);
    issue(0, 2'b00, 1, 32'h13, 32'h0, 0, 32'hFFFFFFDE, 3, 1);
    issue(0, 2'b00, 0, 32'h13, 32'h0, 0, 32'h000000DE, 3, 1);
    issue(1, 2'b01, 0, 32'h20, 32'h12348001, 0, 32'h000000DE, 4, 1);
    issue(0, 2'b01, 1, 32'h20, 32'h0, 0, 32'hFFFF8001, 3, 1);
    issue(0, 2'b01, 1, 32'h21, 32'h0, 1, 32'hFFFF8001, 2, 1);
    issue(1, 2'b10, 0, 32'h22, 32'h11111111, 1, 32'hFFFF8001, 2, 1);
    issue(0, 2'b10, 0, 32'hFD, 32'h0, 1, 32'hFFFF8001, 2, 1);
    issue(0, 2'b11, 0, 32'h0, 32'h0, 1, 32'hFFFF8001, 2, 1);
    issue(0, 2'b00, 0, 32'h100, 32'h0, 1, 32'hFFFF8001, 2, 1);
    issue(0, 2'b10, 0, 32'hFC, 32'h0, 0, 32'h80000000, 3, 1);
    issue(0, 2'b00, 1, 32'hFF, 32'h0, 0, 32'hFFFFFF80, 3, 1);
    drain();
    chk("mem20", 32'(mem[8'h20]), 32'h01);
    chk("mem21", 32'(mem[8'h21]), 32'h80);
    chk("mem22", 32'(mem[8'h22]), 32'h77);
    chk("mem23", 32'(mem[8'h23]), 32'h66);
    issue(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'hDEADBE55, 3, 1);
    req = 1; wr = 1; size = 2'b10; addr = 32'h40; wdata = 32'hFFFFFFFF;
    @(negedge CLK);
    req = 0;
    issue(0, 2'b00, 0, 32'h10, 32'h0, 0, 32'h00000055, 3, 1);
    chk("b2b_done", 32'(last_b2b), 32'd1);
    drain();
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 4; i++) chk($sformatf("mem4%0d_ignored", i), 32'(mem[8'h40 + 8'(i)]), 32'h0);
    issue(1, 2'b10, 0, 32'h30, 32'hCAFEF00D, 0, 32'h0, 3, 0);
    @(posedge CLK);
    #1 Reset = 1;
    @(negedge CLK);
    chk("rst_wr mem_RW", 32'(mem_RW), 32'd0);
    @(posedge CLK);
    #1 Reset = 0;
    @(negedge CLK);
    chk_idle("after_rst");
    for (int i = 0; i < 4; i++) chk($sformatf("mem3%0d_kept", i), 32'(mem[8'h30 + 8'(i)]), 32'h0);
    repeat (5) @(negedge CLK);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
